transmitter: RTL
================

// Module: transmitter
// PURPOSE
//  UART transmit side paired with the team's receiver. Accepts one byte per
//  four-phase req/ack handshake from the host logic and serialises it onto xmit
//  as a 10-slot frame: start(0), 8 data slots, stop(1). Bit timing and slot order
//  match the receiver, so tx->rx loopback needs no glue logic.
// PARAMETERS
//  CLKS_PER_BIT  5220  clk cycles per bit slot (580-clk divider x 9 ticks, as in receiver); min 2
// PORTS
//  clk   in   1  system clock, all state on rising edge
//  clr   in   1  asynchronous, active-low reset
//  req   in   1  host request; data must be stable while req=1
//  data  in   8  byte to send; sampled only on handshake accept
//  ack   out  1  handshake acknowledge
//  busy  out  1  1 from accept until end of stop slot
//  xmit  out  1  serial line, idles high; registered output
// BEHAVIOUR
//  Reset (clr=0, async, immediate): xmit=1, ack=0, busy=0, state=IDLE,
//   shift reg/bit counter/slot index=0. Mid-frame reset truncates the frame; line
//   returns high at once. Receiver recovers on its own reset/next start bit.
//  States: IDLE, HS_ACK, START, DATA, STOP.
//  IDLE: req=1 at an edge -> latch data, ack<=1, busy<=1, go HS_ACK (ack 1 cycle after req).
//  HS_ACK: wait for req=0 (no timeout, xmit stays 1). On req=0: ack<=0, xmit<=0,
//   clear bit counter, go START. xmit falls on same edge ack falls.
//  START/DATA/STOP: each slot holds xmit exactly CLKS_PER_BIT cycles;
//   counter 0..CLKS_PER_BIT-1, slot advances on terminal count, counter wraps to 0.
//  DATA slot order (receiver mapping): slots 1..7 = data[1]..data[7], slot 8 = data[0].
//   Slot index 3 bits, 0..7, no wrap beyond 7 -> STOP.
//  STOP: xmit=1 for CLKS_PER_BIT cycles, then IDLE with busy<=0 on the same edge.
//  Frame: xmit low edge to end of stop = 10*CLKS_PER_BIT cycles exactly.
//  req=1 while busy: ignored (no ack) until IDLE; level still pending then accepted
//   on first IDLE cycle -> back-to-back frames, gap = handshake cycles only.
//  data changes after accept: no effect on the frame in flight.
//  req toggled during HS_ACK beyond first fall: irrelevant, state already left.
//  Counter width $clog2(CLKS_PER_BIT); no other arithmetic.
// STRUCTURE
//  Shared package (uart_pkg): state encodings, FRAME_SLOTS=10, DATA_BITS=8,
//   default CLKS_PER_BIT, slot->data-bit mapping function, shared with receiver.
//  One sub-module: baud_divider (CLKS_PER_BIT param; clr-able counter, 1-cycle
//   slot_done pulse, sync clear input). FSM + shift register stay in transmitter.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  1 Reset: clr=0 mid-DATA -> same cycle xmit=1, ack=0, busy=0; after clr=1 stays IDLE.
//  2 data=8'hA5, req=1 -> ack=1 next edge; req=0 -> ack=0, xmit=0 next edge; slots of 4 clks:
//    0,0,1,0,0,1,0,1,1,1 (start,d1..d7,d0,stop); busy low after 40 clks.
//  3 req held high through HS_ACK for 20 clks -> ack stays 1, xmit stays 1, no frame.
//  4 Host re-raises req with 8'h3C during STOP -> no ack until IDLE; ack 1 cycle after
//    IDLE entry; second frame 0,0,1,1,1,1,0,0,0,1.
//  5 data changed to 8'hFF one cycle after accept of 8'h00 -> all data slots 0.
//  6 Default CLKS_PER_BIT, loopback into receiver: send 8'h5A, 8'hC3 -> receiver
//    req with data 8'h5A then 8'hC3; frame 52200 clks each.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and the slot-to-data-bit
// mapping that keeps the transmitter and the receiver in step.
package uart_pkg;

    localparam int FRAME_SLOTS          = 10;
    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5220;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS_ACK,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Data-phase slot index (0..7, i.e. frame slots 1..8) -> data bit it carries.
    // Slots 1..7 carry data[1]..data[7]; the last data slot carries data[0].
    function automatic logic [2:0] slot_data_bit(input logic [2:0] slot_idx);
        return slot_idx + 3'd1;
    endfunction

    // Reorder a byte so that bit i is the value for data-phase slot i.
    function automatic logic [DATA_BITS-1:0] serial_order(input logic [DATA_BITS-1:0] b);
        logic [DATA_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            r[i] = b[slot_data_bit(3'(i))];
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_divider.sv
// Bit-slot timer: counts 0..CLKS_PER_BIT-1 and pulses slot_done on the terminal
// count, wrapping to 0. sync_clr holds the counter at 0 while no frame is active.
module baud_divider
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clr,
    input  logic sync_clr,
    output logic slot_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, wrap on terminal count, else increment.
    always_comb begin
        if (sync_clr || (cnt_q == TERMINAL)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign slot_done = !sync_clr && (cnt_q == TERMINAL);

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples the pre-edge values, independent of block ordering.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: accepts one byte per four-phase req/ack handshake and sends a
// 10-slot frame (start, 8 data slots in receiver order, stop) on a registered xmit.
module transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       busy,
    output logic       xmit
);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           slot_q, slot_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 xmit_q, xmit_d;
    logic                 slot_done;
    logic                 div_clr;

    // Slot timer only runs while a frame is on the line.
    assign div_clr = (state_q == ST_IDLE) || (state_q == ST_HS_ACK);

    baud_divider #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_divider (
        .clk      (clk),
        .clr      (clr),
        .sync_clr (div_clr),
        .slot_done(slot_done)
    );

    // Next-state logic for handshake, framing and shift register.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        slot_d  = slot_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        xmit_d  = xmit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    shift_d = serial_order(data);
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_HS_ACK;
                end
            end
            ST_HS_ACK: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    xmit_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (slot_done) begin
                    xmit_d  = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    slot_d  = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (slot_done) begin
                    if (slot_q == 3'd7) begin
                        xmit_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        xmit_d  = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        slot_d  = slot_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (slot_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            slot_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            xmit_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            slot_q  <= slot_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            xmit_q  <= xmit_d;
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign xmit = xmit_q;

endmodule
